// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
// XLEN/INSTR_W widths, default reset PC, fetch queue entry layout.
package mips_pkg;

  localparam int XLEN          = 32;
  localparam int INSTR_W       = 32;
  localparam int FETCH_ENTRY_W = XLEN + INSTR_W;

  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, sync active-high reset and flush.
// Ports: push/wdata, pop/rdata (head), flush, empty, full, count.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns fetch PC, issues credit-limited
// req/gnt word fetches, queues {pc,instr} returns, hands them to decode.
// Ports: redirect_i/redirect_pc_i (flush + restart), imem_req_o/
// imem_addr_o/imem_gnt_i, imem_rvalid_i/imem_rdata_i (in order),
// instr_valid_o/instr_o/instr_pc_o/instr_pc4_o/instr_ready_i.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    instr_pc_o,
  output logic [XLEN-1:0]    instr_pc4_o,
  input  logic               instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_nxt;
  logic [CW-1:0]   drop;
  logic [CW:0]     used;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_tag;

  logic accept;
  logic resp;
  logic discard;
  logic keep;
  logic pop;
  logic empty;
  logic full;

  fetch_entry_t push_entry;
  fetch_entry_t head;

  // every issued request reserves a queue slot until it is consumed
  assign used = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_o  = !rst && !redirect_i
                    && (used < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc;

  assign accept  = imem_req_o && imem_gnt_i;
  assign resp    = imem_rvalid_i && (outstanding != '0);
  assign discard = resp && (drop != '0);
  assign keep    = resp && (drop == '0)
                && !redirect_i;
  assign pop     = instr_valid_o && instr_ready_i
                && !redirect_i;

  assign out_nxt = outstanding + CW'(accept)
                 - CW'(resp);

  assign push_entry.pc    = pc_tag;
  assign push_entry.instr = imem_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      pc_tag      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i;
        pc_tag   <= redirect_pc_i;
        // everything still in flight returns stale
        drop     <= out_nxt;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        if (keep)
          pc_tag <= pc_tag + 32'd4;
        if (discard)
          drop <= drop - 1'b1;
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (keep),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = empty ? '0 : head.instr;
  assign instr_pc_o    = empty ? '0 : head.pc;
  assign instr_pc4_o   = instr_pc_o + 32'd4;

  a_rvalid_expected: assert property (
    @(posedge clk) disable iff (rst)
    imem_rvalid_i |-> outstanding != '0
  ) else $error("rvalid with no request outstanding");

  a_push_room: assert property (
    @(posedge clk) disable iff (rst)
    keep |-> (!full || pop)
  ) else $error("push into full fetch queue");

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order variable-latency
// memory model and a consumer-side record of the delivered stream.
module tb_ifetch_queue;

  logic        clk = 0;
  logic        rst = 1;
  logic        redirect_i = 0;
  logic [31:0] redirect_pc_i = 0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 0;
  logic        imem_rvalid_i = 0;
  logic [31:0] imem_rdata_i = 0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc4_o;
  logic        instr_ready_i = 0;

  int vecs = 0;
  int errs = 0;

  int lat = 1;
  bit lat_rand = 0;
  bit gnt_rand = 0;
  bit rv_rand = 0;
  int cyc = 0;

  logic [31:0] pend_a[$];
  int          pend_d[$];
  logic [31:0] req_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_pc4[$];
  logic [31:0] got_ins[$];

  ifetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_pc4_o   (instr_pc4_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // memory model + consumer monitor, sampled at the active edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pend_a.delete();
      pend_d.delete();
    end else begin
      if (imem_rvalid_i && pend_a.size() > 0) begin
        void'(pend_a.pop_front());
        void'(pend_d.pop_front());
      end
      if (imem_req_o && imem_gnt_i) begin
        pend_a.push_back(imem_addr_o);
        pend_d.push_back(cyc +
          (lat_rand ? int'($urandom_range(1, 4)) : lat));
        req_addr.push_back(imem_addr_o);
      end
      if (!redirect_i && instr_valid_o && instr_ready_i) begin
        got_pc.push_back(instr_pc_o);
        got_pc4.push_back(instr_pc4_o);
        got_ins.push_back(instr_o);
      end
    end
  end

  always @(negedge clk) begin
    imem_gnt_i <= gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend_a.size() > 0 && pend_d[0] <= cyc &&
        (!rv_rand || $urandom_range(0, 1) == 1)) begin
      imem_rvalid_i <= 1'b1;
      imem_rdata_i  <= mem_word(pend_a[0]);
    end else begin
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= '0;
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1;
    redirect_i = 0;
    instr_ready_i = 0;
    repeat (2) @(negedge clk);
    #1;
    req_addr.delete();
    got_pc.delete();
    got_pc4.delete();
    got_ins.delete();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (imem_req_o !== 1'b0) begin
      errs++;
      $display("FAIL rst_req got %b want 0", imem_req_o);
    end
    vecs++;
    if (instr_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid got %b want 0", instr_valid_o);
    end
    vecs++;
    if (instr_o !== 32'h0) begin
      errs++;
      $display("FAIL rst_instr got %h want 0", instr_o);
    end
    vecs++;
    if (instr_pc_o !== 32'h0) begin
      errs++;
      $display("FAIL rst_pc got %h want 0", instr_pc_o);
    end
    vecs++;
    if (instr_pc4_o !== 32'h4) begin
      errs++;
      $display("FAIL rst_pc4 got %h want 4", instr_pc4_o);
    end
    rst = 0;
    #1;
    vecs++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errs++;
      $display("FAIL first_req got %b/%h want 1/0",
               imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_stream();
    lat = 1;
    do_reset();
    instr_ready_i = 1;
    repeat (12) @(negedge clk);
    #1;
    vecs++;
    if (req_addr.size() != 12) begin
      errs++;
      $display("FAIL stream_nreq got %0d want 12", req_addr.size());
    end
    for (int i = 0; i < 12; i++) begin
      vecs++;
      if (req_addr[i] !== 32'(4 * i)) begin
        errs++;
        $display("FAIL stream_addr[%0d] got %h want %h",
                 i, req_addr[i], 32'(4 * i));
      end
    end
    vecs++;
    if (got_pc.size() != 10) begin
      errs++;
      $display("FAIL stream_npop got %0d want 10", got_pc.size());
    end
    for (int i = 0; i < 10; i++) begin
      vecs++;
      if (got_pc[i] !== 32'(4 * i) ||
          got_pc4[i] !== 32'(4 * i + 4) ||
          got_ins[i] !== mem_word(32'(4 * i))) begin
        errs++;
        $display("FAIL stream_out[%0d] got %h/%h/%h want %h/%h/%h",
                 i, got_pc[i], got_pc4[i], got_ins[i], 32'(4 * i),
                 32'(4 * i + 4), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    lat = 1;
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    vecs++;
    if (req_addr.size() != 4) begin
      errs++;
      $display("FAIL bp_nreq got %0d want 4", req_addr.size());
    end
    vecs++;
    if (imem_req_o !== 1'b0) begin
      errs++;
      $display("FAIL bp_req got %b want 0", imem_req_o);
    end
    vecs++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin
      errs++;
      $display("FAIL bp_head got %b/%h want 1/0",
               instr_valid_o, instr_pc_o);
    end
    instr_ready_i = 1;
    n = 0;
    while (got_pc.size() < 6 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    vecs++;
    if (got_pc.size() < 6) begin
      errs++;
      $display("FAIL bp_drain got %0d want 6", got_pc.size());
    end
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if (got_pc[i] !== 32'(4 * i) ||
          got_ins[i] !== mem_word(32'(4 * i))) begin
        errs++;
        $display("FAIL bp_out[%0d] got %h/%h want %h/%h", i,
                 got_pc[i], got_ins[i], 32'(4 * i),
                 mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_redirect_drop();
    int n;
    logic [31:0] e;
    lat = 3;
    do_reset();
    instr_ready_i = 1;
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if (req_addr.size() != 3 || instr_valid_o !== 1'b0) begin
      errs++;
      $display("FAIL rd_pre got %0d/%b want 3/0",
               req_addr.size(), instr_valid_o);
    end
    redirect_i = 1;
    redirect_pc_i = 32'h100;
    #1;
    vecs++;
    if (imem_req_o !== 1'b0) begin
      errs++;
      $display("FAIL rd_req got %b want 0", imem_req_o);
    end
    @(negedge clk); #1;
    redirect_i = 0;
    n = 0;
    while (got_pc.size() < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    #1;
    vecs++;
    if (got_pc.size() < 3) begin
      errs++;
      $display("FAIL rd_count got %0d want 3", got_pc.size());
    end
    for (int i = 0; i < 3; i++) begin
      e = 32'h100 + 32'(4 * i);
      vecs++;
      if (got_pc[i] !== e || got_ins[i] !== mem_word(e)) begin
        errs++;
        $display("FAIL rd_out[%0d] got %h/%h want %h/%h",
                 i, got_pc[i], got_ins[i], e, mem_word(e));
      end
    end
  endtask

  task automatic test_redirect_pop_rvalid();
    int n;
    int n0;
    logic [31:0] e;
    lat = 1;
    do_reset();
    instr_ready_i = 1;
    repeat (5) @(negedge clk);
    #1;
    vecs++;
    if (imem_rvalid_i !== 1'b1 || instr_valid_o !== 1'b1) begin
      errs++;
      $display("FAIL rp_setup got %b/%b want 1/1",
               imem_rvalid_i, instr_valid_o);
    end
    n0 = got_pc.size();
    redirect_i = 1;
    redirect_pc_i = 32'h200;
    @(negedge clk); #1;
    redirect_i = 0;
    n = 0;
    while (got_pc.size() < n0 + 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    for (int i = 0; i < n0; i++) begin
      vecs++;
      if (got_pc[i] !== 32'(4 * i)) begin
        errs++;
        $display("FAIL rp_pre[%0d] got %h want %h",
                 i, got_pc[i], 32'(4 * i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      e = 32'h200 + 32'(4 * i);
      vecs++;
      if (got_pc[n0 + i] !== e ||
          got_ins[n0 + i] !== mem_word(e)) begin
        errs++;
        $display("FAIL rp_post[%0d] got %h/%h want %h/%h", i,
                 got_pc[n0 + i], got_ins[n0 + i], e, mem_word(e));
      end
    end
  endtask

  task automatic test_wrap();
    int n;
    int r0;
    int g0;
    logic [31:0] e;
    logic [31:0] e4;
    lat = 1;
    do_reset();
    instr_ready_i = 1;
    repeat (3) @(negedge clk);
    #1;
    r0 = req_addr.size();
    g0 = got_pc.size();
    redirect_i = 1;
    redirect_pc_i = 32'hFFFF_FFF8;
    @(negedge clk); #1;
    redirect_i = 0;
    n = 0;
    while (got_pc.size() < g0 + 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      e  = 32'hFFFF_FFF8 + 32'(4 * i);
      e4 = e + 32'd4;
      vecs++;
      if (req_addr[r0 + i] !== e) begin
        errs++;
        $display("FAIL wrap_addr[%0d] got %h want %h",
                 i, req_addr[r0 + i], e);
      end
      vecs++;
      if (got_pc[g0 + i] !== e || got_pc4[g0 + i] !== e4 ||
          got_ins[g0 + i] !== mem_word(e)) begin
        errs++;
        $display("FAIL wrap_out[%0d] got %h/%h/%h want %h/%h/%h",
                 i, got_pc[g0 + i], got_pc4[g0 + i],
                 got_ins[g0 + i], e, e4, mem_word(e));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    lat_rand = 1;
    gnt_rand = 1;
    rv_rand = 1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      instr_ready_i = 1'($urandom_range(0, 1));
    end
    lat_rand = 0;
    gnt_rand = 0;
    rv_rand = 0;
    lat = 1;
    instr_ready_i = 1;
    repeat (30) @(negedge clk);
    #1;
    vecs++;
    if (got_pc.size() < 60) begin
      errs++;
      $display("FAIL rand_count got %0d want >=60", got_pc.size());
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      e = 32'(4 * i);
      vecs++;
      if (got_pc[i] !== e || got_pc4[i] !== e + 32'd4 ||
          got_ins[i] !== mem_word(e)) begin
        errs++;
        $display("FAIL rand_out[%0d] got %h/%h/%h want %h/%h/%h",
                 i, got_pc[i], got_pc4[i], got_ins[i],
                 e, e + 32'd4, mem_word(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 2;
    do_reset();
    instr_ready_i = 1;
    repeat (6) @(negedge clk);
    #1;
    rst = 1;
    #1;
    vecs++;
    if (imem_req_o !== 1'b0) begin
      errs++;
      $display("FAIL mid_req got %b want 0", imem_req_o);
    end
    @(negedge clk); #1;
    vecs++;
    if (instr_valid_o !== 1'b0 || instr_pc_o !== 32'h0 ||
        instr_o !== 32'h0 || instr_pc4_o !== 32'h4) begin
      errs++;
      $display("FAIL mid_clear got %b/%h/%h/%h want 0/0/0/4",
               instr_valid_o, instr_pc_o, instr_o, instr_pc4_o);
    end
    got_pc.delete();
    got_pc4.delete();
    got_ins.delete();
    rst = 0;
    n = 0;
    while (got_pc.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if (got_pc[i] !== 32'(4 * i) ||
          got_ins[i] !== mem_word(32'(4 * i))) begin
        errs++;
        $display("FAIL mid_out[%0d] got %h/%h want %h/%h", i,
                 got_pc[i], got_ins[i], 32'(4 * i),
                 mem_word(32'(4 * i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_pop_rvalid();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
